// File: rtl/issue_credit_ctrl.sv
// issue_credit_ctrl
//   Credit/occupancy controller in front of the Tomasulo issue stage.
//   It counts the occupied ROB, RS and LSB entries and hands out ROB
//   destination tags (1..ROB_SIZE; 0 is reserved for "no producer").
//   It drives a single conservative stall line and clears all credits on a
//   ROB-bus flush.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   rdy                 : global ready; when low all state holds
//   issue_valid         : issuer wants to issue this cycle
//   issue_is_ls         : 1 = load/store (LSB), 0 = RS-bound
//   rs_release          : one RS entry freed
//   ls_release          : one LSB entry freed
//   rob_commit          : ROB head retired
//   reset_from_rob_bus  : misprediction flush (keeps err)
//   dest_to_issuer      : tag for the next issued instruction (tail pointer)
//   is_any_full         : stall issue
//   rob/rs/lsb_count    : occupancy counters
//   err                 : sticky protocol-violation flag
module issue_credit_ctrl #(
  parameter int ROB_SIZE  = 16,
  parameter int RS_SIZE   = 16,
  parameter int LSB_SIZE  = 16,
  parameter int ID_WIDTH  = 5,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 issue_valid,
  input  logic                 issue_is_ls,
  input  logic                 rs_release,
  input  logic                 ls_release,
  input  logic                 rob_commit,
  input  logic                 reset_from_rob_bus,
  output logic [ID_WIDTH-1:0]  dest_to_issuer,
  output logic                 is_any_full,
  output logic [CNT_WIDTH-1:0] rob_count,
  output logic [CNT_WIDTH-1:0] rs_count,
  output logic [CNT_WIDTH-1:0] lsb_count,
  output logic                 err
);

  localparam logic [ID_WIDTH-1:0]  TAG_FIRST = ID_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]  TAG_LAST  = ID_WIDTH'(ROB_SIZE);
  localparam logic [CNT_WIDTH-1:0] ROB_FULL  = CNT_WIDTH'(ROB_SIZE);
  localparam logic [CNT_WIDTH-1:0] RS_FULL   = CNT_WIDTH'(RS_SIZE);
  localparam logic [CNT_WIDTH-1:0] LSB_FULL  = CNT_WIDTH'(LSB_SIZE);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [ID_WIDTH-1:0]  tail_q, tail_d;
  logic [ID_WIDTH-1:0]  head_q, head_d;
  logic [CNT_WIDTH-1:0] rob_cnt_q, rob_cnt_d;
  logic [CNT_WIDTH-1:0] rs_cnt_q, rs_cnt_d;
  logic [CNT_WIDTH-1:0] lsb_cnt_q, lsb_cnt_d;
  logic                 err_q, err_d;

  logic full;
  logic issue_acc, issue_bad;
  logic rs_inc, lsb_inc;
  logic rs_dec, lsb_dec, rob_dec;
  logic rs_bad, lsb_bad, rob_bad;

  // Tags cycle 1..ROB_SIZE and never land on 0.
  function automatic logic [ID_WIDTH-1:0] next_tag(input logic [ID_WIDTH-1:0] t);
    return (t == TAG_LAST) ? TAG_FIRST : t + TAG_FIRST;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_WIDTH-1:0] r;
    r = c;
    if (inc && !dec) r = c + CNT_ONE;
    if (!inc && dec) r = c - CNT_ONE;
    return r;
  endfunction

  // Stall looks only at registered counts: the instruction type is not known
  // yet, and a same-cycle release only helps from the next cycle on.
  assign full = (rob_cnt_q == ROB_FULL) | (rs_cnt_q == RS_FULL) |
                (lsb_cnt_q == LSB_FULL);

  always_comb begin
    issue_acc = issue_valid & ~full;
    issue_bad = issue_valid &  full;
    rs_inc    = issue_acc & ~issue_is_ls;
    lsb_inc   = issue_acc &  issue_is_ls;

    // Releasing/committing an empty counter is a violation and is dropped.
    rs_bad    = rs_release & (rs_cnt_q  == '0);
    lsb_bad   = ls_release & (lsb_cnt_q == '0);
    rob_bad   = rob_commit & (rob_cnt_q == '0);
    rs_dec    = rs_release & ~rs_bad;
    lsb_dec   = ls_release & ~lsb_bad;
    rob_dec   = rob_commit & ~rob_bad;

    tail_d    = issue_acc ? next_tag(tail_q) : tail_q;
    head_d    = rob_dec   ? next_tag(head_q) : head_q;
    rob_cnt_d = bump(rob_cnt_q, issue_acc, rob_dec);
    rs_cnt_d  = bump(rs_cnt_q,  rs_inc,    rs_dec);
    lsb_cnt_d = bump(lsb_cnt_q, lsb_inc,   lsb_dec);
    err_d     = err_q | issue_bad | rs_bad | lsb_bad | rob_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tail_q    <= TAG_FIRST;
      head_q    <= TAG_FIRST;
      rob_cnt_q <= '0;
      rs_cnt_q  <= '0;
      lsb_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (reset_from_rob_bus) begin
      // Flush drops everything in flight but keeps the sticky error.
      tail_q    <= TAG_FIRST;
      head_q    <= TAG_FIRST;
      rob_cnt_q <= '0;
      rs_cnt_q  <= '0;
      lsb_cnt_q <= '0;
    end else if (rdy) begin
      tail_q    <= tail_d;
      head_q    <= head_d;
      rob_cnt_q <= rob_cnt_d;
      rs_cnt_q  <= rs_cnt_d;
      lsb_cnt_q <= lsb_cnt_d;
      err_q     <= err_d;
    end
  end

  assign dest_to_issuer = tail_q;
  assign is_any_full    = full;
  assign rob_count      = rob_cnt_q;
  assign rs_count       = rs_cnt_q;
  assign lsb_count      = lsb_cnt_q;
  assign err            = err_q;

endmodule

// File: tb/tb_issue_credit_ctrl.sv
module tb_issue_credit_ctrl;

  logic clk = 1'b0;
  logic rst, rdy, issue_valid, issue_is_ls, rs_release, ls_release;
  logic rob_commit, reset_from_rob_bus;

  logic [4:0] a_dest, a_rob, a_rs, a_lsb;
  logic       a_full, a_err;
  logic [4:0] b_dest, b_rob, b_rs, b_lsb;
  logic       b_full, b_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // A: default sizes; B: ROB_SIZE = 4 for the wrap/full scenarios.
  issue_credit_ctrl u_a (
    .clk(clk), .rst(rst), .rdy(rdy), .issue_valid(issue_valid),
    .issue_is_ls(issue_is_ls), .rs_release(rs_release), .ls_release(ls_release),
    .rob_commit(rob_commit), .reset_from_rob_bus(reset_from_rob_bus),
    .dest_to_issuer(a_dest), .is_any_full(a_full), .rob_count(a_rob),
    .rs_count(a_rs), .lsb_count(a_lsb), .err(a_err)
  );

  issue_credit_ctrl #(.ROB_SIZE(4)) u_b (
    .clk(clk), .rst(rst), .rdy(rdy), .issue_valid(issue_valid),
    .issue_is_ls(issue_is_ls), .rs_release(rs_release), .ls_release(ls_release),
    .rob_commit(rob_commit), .reset_from_rob_bus(reset_from_rob_bus),
    .dest_to_issuer(b_dest), .is_any_full(b_full), .rob_count(b_rob),
    .rs_count(b_rs), .lsb_count(b_lsb), .err(b_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; rdy = 1; issue_valid = 0; issue_is_ls = 0; rs_release = 0;
    ls_release = 0; rob_commit = 0; reset_from_rob_bus = 0;
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked there too.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_rst();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic issue(input logic ls);
    issue_valid = 1; issue_is_ls = ls; step(); issue_valid = 0; issue_is_ls = 0;
  endtask

  initial begin
    idle();
    #2;
    do_rst();
    chk("rst_rob",  a_rob, 0);
    chk("rst_rs",   a_rs, 0);
    chk("rst_lsb",  a_lsb, 0);
    chk("rst_dest", a_dest, 1);
    chk("rst_full", a_full, 0);
    chk("rst_err",  a_err, 0);
    chk("rst_dest_b", b_dest, 1);

    // Three issues RS, LS, RS: tag 1 -> 2 -> 3 -> 4
    issue(0); chk("tag2", a_dest, 2);
    issue(1); chk("tag3", a_dest, 3);
    issue(0); chk("tag4", a_dest, 4);
    chk("s1_rob", a_rob, 3);
    chk("s1_rs",  a_rs, 2);
    chk("s1_lsb", a_lsb, 1);
    chk("s1_full", a_full, 0);

    // B (ROB_SIZE=4): 4th issue fills ROB, tag wraps to 1
    issue(0);
    chk("b_full4", b_full, 1);
    chk("b_rob4",  b_rob, 4);
    chk("b_wrap",  b_dest, 1);
    chk("b_err4",  b_err, 0);
    issue(0);
    chk("b_err5",  b_err, 1);
    chk("b_rob5",  b_rob, 4);
    chk("b_tag5",  b_dest, 1);
    chk("a_rob5",  a_rob, 5);
    chk("a_tag5",  a_dest, 6);

    // Commit + issue while full: issue rejected, count drops
    rob_commit = 1; issue(0); rob_commit = 0;
    chk("b_cmt_rob",  b_rob, 3);
    chk("b_cmt_full", b_full, 0);
    chk("b_cmt_tag",  b_dest, 1);
    issue(0);
    chk("b_reiss_rob", b_rob, 4);
    chk("b_reiss_tag", b_dest, 2);

    // RS count 2, issue RS + rs_release nets to zero
    do_rst();
    chk("rst2_err_b", b_err, 0);
    issue(0); issue(0);
    chk("s4_rs0", a_rs, 2);
    rs_release = 1; issue(0); rs_release = 0;
    chk("s4_rs",  a_rs, 2);
    chk("s4_rob", a_rob, 3);
    chk("s4_tag", a_dest, 4);

    // rdy low: pulses are ignored for 3 cycles
    do_rst();
    issue(0);
    rdy = 0; issue_valid = 1; rs_release = 1; rob_commit = 1; ls_release = 1;
    step(); step(); step();
    idle();
    chk("rdy_rob", a_rob, 1);
    chk("rdy_rs",  a_rs, 1);
    chk("rdy_lsb", a_lsb, 0);
    chk("rdy_tag", a_dest, 2);
    chk("rdy_err", a_err, 0);

    // ls_release on empty LSB
    ls_release = 1; step(); ls_release = 0;
    chk("lsb_und_err", a_err, 1);
    chk("lsb_und_cnt", a_lsb, 0);

    // Flush with rob_count = 5 and a simultaneous issue
    issue(0); issue(1); issue(0); issue(1);
    chk("pre_fl_rob", a_rob, 5);
    chk("pre_fl_lsb", a_lsb, 2);
    chk("pre_fl_tag", a_dest, 6);
    reset_from_rob_bus = 1; rs_release = 1; issue(0); idle();
    chk("fl_rob",  a_rob, 0);
    chk("fl_rs",   a_rs, 0);
    chk("fl_lsb",  a_lsb, 0);
    chk("fl_tag",  a_dest, 1);
    chk("fl_err",  a_err, 1);

    // Hard reset clears err
    do_rst();
    chk("rst3_err", a_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
